// File: rtl/top_pkg.sv
// top_pkg: shared constants and types for the serial-in / FIFO / serial-out block.
//   WIDTH_DEFAULT : default bits per word
//   DEPTH_DEFAULT : default FIFO capacity in words (power of two, >= 2)
//   CNT_W_DEFAULT : width of a FIFO occupancy count for the default depth
//   cnt_width()   : occupancy-count width for any depth, $clog2(depth+1)
//   ser_state_e   : serializer state (IDLE / SHIFT)
`timescale 1ns/1ps
package top_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = $clog2(DEPTH_DEFAULT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Count must represent 0..depth inclusive, hence depth+1 values.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/top_fifo.sv
// top_fifo: synchronous word FIFO with occupancy count.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (pointers and count)
//   push_i   : write wdata_i when not full
//   pop_i    : advance head when not empty
//   wdata_i  : word to push
//   rdata_o  : current head word (valid while not empty)
//   full_o   : count == DEPTH
//   empty_o  : count == 0
//   count_o  : words held, 0..DEPTH
// Push and pop in the same cycle leave the count unchanged; full/empty are
// taken from the registered count, so a same-cycle pop does not free a slot.
`timescale 1ns/1ps
module top_fifo
    import top_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/top.sv
// top: serial deserializer -> word FIFO -> serial serializer.
//   clock_1MHz : system clock, all state on rising edge
//   rst        : synchronous active-high reset
//   data_in    : serial input bit, taken when a write is accepted
//   write_in   : accept one bit per edge while high and status_out=1
//   enqueue_in : push the complete staged word into the FIFO
//   dequeue_in : pop the FIFO head and shift it out on data_out
//   status_out : registered; 1 when the stager holds fewer than WIDTH bits
//   data_out   : registered serial output, 0 while the serializer is idle
// Build option: define TOP_MSB_FIRST_EN to stage and emit words MSB first;
// the default build is LSB first. The port list is the same in both builds.
`timescale 1ns/1ps
module top
    import top_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic clock_1MHz,
    input  logic rst,
    input  logic data_in,
    input  logic write_in,
    input  logic enqueue_in,
    input  logic dequeue_in,
    output logic status_out,
    output logic data_out
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int BC_W  = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0]  BC_ONE    = BC_W'(1);
    localparam logic [BC_W-1:0]  BC_FULL   = BC_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage_q, stage_d;
    logic [BC_W-1:0]  bit_count_q, bit_count_d;
    logic             status_q, status_d;
    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  ser_cnt_q, ser_cnt_d;
    logic             dout_q, dout_d;

    logic             fifo_push, fifo_pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [WIDTH-1:0] fifo_rdata;
    logic             ser_last, ser_ready;

    top_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clock_1MHz),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (stage_q),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign status_out = status_q;
    assign data_out   = dout_q;

    // Deserializer: a full stager blocks writes, so write and enqueue can
    // never both be accepted in one cycle.
    always_comb begin
        stage_d     = stage_q;
        bit_count_d = bit_count_q;
        fifo_push   = 1'b0;
        if (bit_count_q == BC_FULL) begin
            if (enqueue_in && !fifo_full) begin
                fifo_push   = 1'b1;
                bit_count_d = '0;
            end
        end else if (write_in && status_q) begin
`ifdef TOP_MSB_FIRST_EN
            stage_d = {stage_q[WIDTH-2:0], data_in};
`else
            stage_d = {data_in, stage_q[WIDTH-1:1]};
`endif
            bit_count_d = bit_count_q + BC_ONE;
        end
        status_d = (bit_count_d != BC_FULL);
    end

    // Serializer: ser_cnt_q counts bits still to be shown, including the one
    // currently on data_out, so a new word may load on the last bit's edge.
    assign ser_last  = (state_q == SHIFT) && (ser_cnt_q == BC_ONE);
    assign ser_ready = (state_q == IDLE) || ser_last;
    assign fifo_pop  = dequeue_in && !fifo_empty && ser_ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        ser_cnt_d = ser_cnt_q;
        dout_d    = dout_q;
        if (fifo_pop) begin
            state_d   = SHIFT;
            ser_cnt_d = BC_FULL;
`ifdef TOP_MSB_FIRST_EN
            dout_d  = fifo_rdata[WIDTH-1];
            shreg_d = fifo_rdata << 1;
`else
            dout_d  = fifo_rdata[0];
            shreg_d = fifo_rdata >> 1;
`endif
        end else if (state_q == SHIFT) begin
            if (ser_last) begin
                state_d   = IDLE;
                ser_cnt_d = '0;
                dout_d    = 1'b0;
            end else begin
                ser_cnt_d = ser_cnt_q - BC_ONE;
`ifdef TOP_MSB_FIRST_EN
                dout_d  = shreg_q[WIDTH-1];
                shreg_d = shreg_q << 1;
`else
                dout_d  = shreg_q[0];
                shreg_d = shreg_q >> 1;
`endif
            end
        end
    end

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            stage_q     <= '0;
            bit_count_q <= '0;
            status_q    <= 1'b0;
            state_q     <= IDLE;
            shreg_q     <= '0;
            ser_cnt_q   <= '0;
            dout_q      <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            bit_count_q <= bit_count_d;
            status_q    <= status_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            ser_cnt_q   <= ser_cnt_d;
            dout_q      <= dout_d;
        end
    end

    // Occupancy can never exceed capacity.
    always_ff @(posedge clock_1MHz) begin
        if (!rst) assert (fifo_count <= CNT_DEPTH);
    end

endmodule

// File: tb/tb_top.sv
// tb_top: directed self-checking bench for top (default LSB-first build,
// WIDTH=8, DEPTH=8). Inputs change 1ns after each rising edge; outputs are
// sampled at that same point, well away from the next active edge.
`timescale 1ns/1ps
module tb_top;

    logic clock_1MHz = 1'b0;
    logic rst, data_in, write_in, enqueue_in, dequeue_in;
    logic status_out, data_out;

    int tests  = 0;
    int failed = 0;

    top #(.WIDTH(8), .DEPTH(8)) dut (
        .clock_1MHz (clock_1MHz),
        .rst        (rst),
        .data_in    (data_in),
        .write_in   (write_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .status_out (status_out),
        .data_out   (data_out)
    );

    always #5 clock_1MHz = ~clock_1MHz;

    task automatic step();
        @(posedge clock_1MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write bits lo..hi of w (bit lo first), checking status_out before each.
    task automatic write_bits(input logic [7:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            check("status_before_write", status_out, 1);
            write_in = 1'b1;
            data_in  = w[i];
            step();
        end
        write_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic enqueue();
        enqueue_in = 1'b1;
        step();
        enqueue_in = 1'b0;
    endtask

    // Pulse dequeue, then collect the 8 serial bits (LSB first on the wire).
    task automatic dequeue_word(output logic [7:0] w);
        dequeue_in = 1'b1;
        step();
        dequeue_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w[i] = data_out;
            step();
        end
    endtask

    logic [7:0]  w;
    logic [15:0] pair;

    initial begin
        rst = 1'b1; data_in = 1'b0; write_in = 1'b0;
        enqueue_in = 1'b0; dequeue_in = 1'b0;
        step();
        step();
        check("rst_status", status_out, 0);
        check("rst_dout", data_out, 0);
        rst = 1'b0;
        step();
        check("status_after_rst", status_out, 1);

        // Word 0xAA written LSB first: 0,1,0,1,0,1,0,1
        write_bits(8'hAA, 0, 7);
        check("status_word_full", status_out, 0);
        write_in = 1'b1; data_in = 1'b1;
        step();
        write_in = 1'b0; data_in = 1'b0;
        check("status_write_when_full", status_out, 0);
        enqueue();
        check("status_after_enqueue", status_out, 1);
        dequeue_word(w);
        check("word_aa", w, 8'hAA);
        check("dout_idle_after_aa", data_out, 0);

        // Partial word: enqueue after 3 bits is ignored, FIFO stays empty
        write_bits(8'h4B, 0, 2);
        enqueue();
        check("status_partial_enqueue", status_out, 1);
        dequeue_in = 1'b1;
        step();
        dequeue_in = 1'b0;
        check("dout_dequeue_empty", data_out, 0);
        step();
        check("dout_dequeue_empty_2", data_out, 0);
        write_bits(8'h4B, 3, 7);
        check("status_partial_complete", status_out, 0);
        enqueue();
        dequeue_word(w);
        check("word_4b", w, 8'h4B);

        // Fill FIFO with 0x00..0x07, 9th enqueue rejected
        for (int k = 0; k < 8; k++) begin
            write_bits(8'(k), 0, 7);
            enqueue();
            check("status_after_fill_enq", status_out, 1);
        end
        write_bits(8'hFF, 0, 7);
        enqueue();
        check("status_enqueue_when_full", status_out, 0);
        for (int k = 0; k < 8; k++) begin
            dequeue_word(w);
            check("fifo_order", w, k);
        end
        check("status_word_retained", status_out, 0);
        enqueue();
        check("status_retained_pushed", status_out, 1);
        dequeue_word(w);
        check("word_ff_retained", w, 8'hFF);

        // Held dequeue streams two words back to back, then idles
        write_bits(8'h3C, 0, 7);
        enqueue();
        write_bits(8'hC5, 0, 7);
        enqueue();
        pair = 16'hC53C;
        dequeue_in = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            check("stream_bit", data_out, (c < 16) ? pair[c] : 1'b0);
        end
        dequeue_in = 1'b0;

        // Reset mid-shift discards everything
        write_bits(8'h96, 0, 7);
        enqueue();
        write_bits(8'h11, 0, 7);
        enqueue();
        write_bits(8'h07, 0, 2);
        dequeue_in = 1'b1;
        step();
        dequeue_in = 1'b0;
        check("mid_shift_bit0", data_out, 0);
        step();
        check("mid_shift_bit1", data_out, 1);
        step();
        rst = 1'b1;
        step();
        check("dout_after_mid_rst", data_out, 0);
        check("status_during_rst", status_out, 0);
        rst = 1'b0;
        step();
        check("status_after_mid_rst", status_out, 1);
        dequeue_in = 1'b1;
        step();
        dequeue_in = 1'b0;
        check("fifo_empty_after_rst", data_out, 0);
        step();
        check("fifo_empty_after_rst_2", data_out, 0);
        write_bits(8'h5A, 0, 7);
        check("status_fresh_word", status_out, 0);
        enqueue();
        dequeue_word(w);
        check("word_5a_after_rst", w, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter WIDTH, default 8, sets the bits per word: deserializer length, FIFO word width and serializer length.
REQ-002 Parameter DEPTH, default 8, sets the FIFO word capacity; it SHALL be a power of two, at least 2.
REQ-003 clock_1MHz  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 data_in  input  1  serial data bit, sampled when a write is accepted.
REQ-006 write_in  input  1  level strobe; one bit is accepted per rising edge while high and status_out=1.
REQ-007 enqueue_in  input  1  request to push the assembled word into the FIFO.
REQ-008 dequeue_in  input  1  request to pop the FIFO head and shift it out on data_out.
REQ-009 status_out  output  1  high when the deserializer can accept a bit, i.e. it holds fewer than WIDTH bits.
REQ-010 data_out  output  1  serial output bit stream.

Function
REQ-011 Write acceptance: write_in=1 and status_out=1 at a rising edge SHALL shift data_in into the staging register and increment bit_count, which is 0..WIDTH.
REQ-012 Default bit order: the first accepted bit SHALL become word bit 0 (LSB first).
REQ-013 When bit_count=WIDTH, status_out SHALL be 0 and further writes SHALL be ignored, with no staging change.
REQ-014 Enqueue acceptance: enqueue_in=1 with bit_count=WIDTH and FIFO count<DEPTH SHALL push the staged word, clear bit_count to 0 and set status_out=1 on the next cycle.
REQ-015 Enqueue with bit_count<WIDTH SHALL be ignored; the partial word and its count are kept.
REQ-016 Enqueue with the FIFO full (count=DEPTH, sampled before any same-cycle pop) SHALL be ignored; the staged word is retained.
REQ-017 Write and enqueue in the same cycle: only one can be accepted, by REQ-013/014; no conflict arises.
REQ-018 Dequeue acceptance: dequeue_in=1 with FIFO non-empty and serializer idle SHALL pop the head into the output shift register and set the serializer busy for WIDTH cycles.
REQ-019 Serializer output: data_out SHALL present word bit 0 in the cycle after acceptance, then bit 1, and so on, one bit per cycle.
REQ-020 data_out SHALL be 0 whenever the serializer is idle.
REQ-021 Dequeue while the FIFO is empty or the serializer is busy SHALL be ignored.
REQ-022 A new dequeue MAY be accepted on the edge that ends the last bit, so back-to-back words stream without a gap.
REQ-023 Enqueue and dequeue accepted in the same cycle SHALL leave the FIFO count unchanged.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; data order SHALL be strictly first-in, first-out.
REQ-025 All outputs SHALL be driven from registered state; there is no combinational path from any input to any output.

Reset
REQ-026 While rst=1 at an edge: bit_count=0, staging register=0, FIFO count and pointers=0, serializer idle, data_out=0.
REQ-027 status_out SHALL be 0 while rst is high and 1 from the first edge with rst low.
REQ-028 Reset asserted mid-word or mid-shift SHALL discard the partial word, all queued words and the word being shifted.

Configuration
REQ-029 Macro TOP_MSB_FIRST_EN: when defined, the first accepted bit SHALL become bit WIDTH-1, and the serializer SHALL emit bit WIDTH-1 first.
REQ-030 When TOP_MSB_FIRST_EN is undefined, both deserializer and serializer SHALL be LSB first; the interface is identical in both builds.

Structure
REQ-031 Package top_pkg SHALL hold the WIDTH/DEPTH defaults, the count-width constant $clog2(DEPTH+1), and the serializer state enum IDLE/SHIFT.
REQ-032 The FIFO SHALL be one sub-module, top_fifo, with push, pop, full, empty and count; deserializer and serializer logic stay in top.

Verification
REQ-033 Reset 2 cycles, then write bits 0,1,0,1,0,1,0,1 -> status_out is 1 before each write and 0 after the 8th; staged word = 0xAA.
REQ-034 Enqueue pulse after REQ-033, then dequeue -> status_out returns to 1, and data_out shows 0,1,0,1,0,1,0,1 over 8 cycles, then 0.
REQ-035 Enqueue after only 3 writes -> ignored; FIFO stays empty, and 5 more writes complete the word.
REQ-036 Enqueue 8 words 0x00..0x07, then a 9th word -> 9th enqueue ignored and status_out stays 0; dequeues return 0x00..0x07 in order.
REQ-037 Dequeue pulse held 20 cycles with 2 words queued -> exactly two back-to-back 8-bit words, then data_out=0.
REQ-038 rst asserted mid-shift -> data_out=0 next cycle, FIFO empty, and status_out=1 once rst drops.
